// File: rtl/pwm_duty_capture_pkg.sv
// Shared types and defaults for the PWM duty-cycle capture block.
//   state_t  : capture FSM states (IDLE, ARM, MEAS)
//   sample_t : one measured sample at the default counter width
package pwm_duty_capture_pkg;

  localparam int unsigned DEF_CNT_WIDTH   = 12;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_CNT_WIDTH-1:0] period;
    logic [DEF_CNT_WIDTH-1:0] high;
    logic                     stuck;
    logic                     level;
  } sample_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser with rising-edge detection for an asynchronous input.
//   clk, rst_n : clock, asynchronous active-low reset
//   async_in   : asynchronous input
//   synced     : async_in after SYNC_STAGES flops
//   rise       : synced & ~(synced delayed one cycle), combinational
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic synced,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~prev_q;

endmodule

// File: rtl/pwm_duty_capture.sv
// Measures period (rise to rise) and high time of an asynchronous PWM input,
// one sample per period, delivered through a one-entry valid/ready buffer.
// A period reaching 2^CNT_WIDTH-1 cycles without a rise yields a stuck sample.
//   clk, rst_n   : clock, asynchronous active-low reset
//   pwm_in       : asynchronous PWM input
//   enable       : measurement enable (0 returns to IDLE, clears overrun_flag)
//   s_valid/ready: sample handshake
//   s_period     : period in clk cycles
//   s_high       : cycles with synced input high within the period
//   s_stuck      : sample produced by timeout
//   s_level      : synced level at timeout (0 for edge samples)
//   overrun      : one-cycle pulse when a sample is dropped
//   overrun_flag : sticky overrun
module pwm_duty_capture
  import pwm_duty_capture_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pwm_in,
  input  logic                 enable,
  output logic                 s_valid,
  input  logic                 s_ready,
  output logic [CNT_WIDTH-1:0] s_period,
  output logic [CNT_WIDTH-1:0] s_high,
  output logic                 s_stuck,
  output logic                 s_level,
  output logic                 overrun,
  output logic                 overrun_flag
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic synced;
  logic rise;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (pwm_in),
    .synced   (synced),
    .rise     (rise)
  );

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_q, high_d;
  logic                 emit;
  logic                 emit_stuck;
  logic                 load;
  logic                 drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      period_q <= '0;
      high_q   <= '0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      high_q   <= high_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    high_d     = high_q;
    emit       = 1'b0;
    emit_stuck = 1'b0;
    if (!enable) begin
      state_d  = IDLE;
      period_d = '0;
      high_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = ARM;
          period_d = '0;
          high_d   = '0;
        end
        ARM: begin
          if (rise) begin
            state_d  = MEAS;
            period_d = CNT_ONE;
            high_d   = CNT_ONE;
          end
        end
        MEAS: begin
          if (rise) begin
            emit     = 1'b1;
            period_d = CNT_ONE;
            high_d   = CNT_ONE;
          end else if (period_q == CNT_MAX) begin
            // Saturated without an edge: report the stuck level and re-arm.
            emit       = 1'b1;
            emit_stuck = 1'b1;
            state_d    = ARM;
            period_d   = '0;
            high_d     = '0;
          end else begin
            period_d = period_q + CNT_ONE;
            high_d   = high_q + {{(CNT_WIDTH-1){1'b0}}, synced};
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A consumer taking the current entry frees the slot in the same cycle.
  assign load = emit & (~s_valid | s_ready);
  assign drop = emit & s_valid & ~s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid      <= 1'b0;
      s_period     <= '0;
      s_high       <= '0;
      s_stuck      <= 1'b0;
      s_level      <= 1'b0;
      overrun      <= 1'b0;
      overrun_flag <= 1'b0;
    end else begin
      overrun <= drop;
      if (!enable) begin
        overrun_flag <= 1'b0;
      end else if (drop) begin
        overrun_flag <= 1'b1;
      end
      if (load) begin
        s_valid  <= 1'b1;
        s_period <= period_q;
        s_high   <= high_q;
        s_stuck  <= emit_stuck;
        s_level  <= emit_stuck & synced;
      end else if (s_valid && s_ready) begin
        s_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_capture.sv
module tb_pwm_duty_capture;
  import pwm_duty_capture_pkg::*;

  localparam int unsigned W    = 12;
  localparam int unsigned MAXP = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pwm_in;
  logic         enable;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_period;
  logic [W-1:0] s_high;
  logic         s_stuck;
  logic         s_level;
  logic         overrun;
  logic         overrun_flag;

  pwm_duty_capture #(.CNT_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwm_in       (pwm_in),
    .enable       (enable),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_period     (s_period),
    .s_high       (s_high),
    .s_stuck      (s_stuck),
    .s_level      (s_level),
    .overrun      (overrun),
    .overrun_flag (overrun_flag)
  );

  always #5 clk = ~clk;

  // Accepted samples and overrun pulses, observed on the falling edge.
  sample_t     got_q[$];
  int unsigned ovr_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && s_valid && s_ready)
      got_q.push_back(sample_t'{period: s_period, high: s_high, stuck: s_stuck, level: s_level});
    if (rst_n && overrun)
      ovr_cnt++;
  end

  sample_t     exp_q[$];
  int          rd;
  int          n_cmp;
  int          n_bad;
  int unsigned ovr_snap;
  int unsigned rp[9];
  int unsigned rh[9];

  // Reference model: a clean period gives (P, H); a missing edge gives a
  // saturated period with the high run clipped to the counter range.
  function automatic sample_t edge_sample(int unsigned p, int unsigned h);
    sample_t s;
    s.period = W'(p);
    s.high   = W'(h);
    s.stuck  = 1'b0;
    s.level  = 1'b0;
    return s;
  endfunction

  function automatic sample_t timeout_sample(int unsigned high_run, logic lvl);
    sample_t s;
    s.period = W'(MAXP);
    s.high   = W'((high_run > MAXP) ? MAXP : high_run);
    s.stuck  = 1'b1;
    s.level  = lvl;
    return s;
  endfunction

  task automatic tick(int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_period(int unsigned p, int unsigned h);
    pwm_in = 1'b1;
    tick(h);
    pwm_in = 1'b0;
    tick(p - h);
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the expected samples, then compare count and contents.
  task automatic chk_samples(string tag, int unsigned budget);
    int need;
    need = rd + exp_q.size();
    for (int unsigned i = 0; i < budget && got_q.size() < need; i++) tick(1);
    chk({tag, "_count"}, 32'(got_q.size() - rd), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rd + i < got_q.size())
        chk($sformatf("%s_s%0d", tag, i), 32'(got_q[rd + i]), 32'(exp_q[i]));
    end
    rd = got_q.size();
    exp_q.delete();
  endtask

  task automatic restart(logic rdy);
    enable  = 1'b0;
    s_ready = rdy;
    pwm_in  = 1'b0;
    tick(3);
    enable = 1'b1;
    tick(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rd     = 0;
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    enable = 1'b0;
    s_ready = 1'b0;
    tick(3);
    chk("rst_flags", {27'd0, s_valid, s_stuck, s_level, overrun, overrun_flag}, 32'd0);
    chk("rst_period", 32'(s_period), 32'd0);
    chk("rst_high", 32'(s_high), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 1: period 1024 / high 300, five edges, four samples.
    restart(1'b1);
    drive_period(1024, 300);
    chk("t1_arm_only", 32'(got_q.size() - rd), 32'd0);
    pwm_in = 1'b1;
    tick(1);
    chk("t1_lat_n", {31'd0, s_valid}, 32'd0);
    tick(1);
    chk("t1_lat_n1", {31'd0, s_valid}, 32'd0);
    tick(1);
    chk("t1_lat_n2", {31'd0, s_valid}, 32'd1);
    tick(297);
    pwm_in = 1'b0;
    tick(724);
    drive_period(1024, 300);
    drive_period(1024, 300);
    pwm_in = 1'b1;
    tick(300);
    pwm_in = 1'b0;
    tick(10);
    repeat (4) exp_q.push_back(edge_sample(1024, 300));
    chk_samples("t1", 50);

    // Randomized clean periods against the model.
    restart(1'b1);
    for (int i = 0; i < 9; i++) begin
      rp[i] = $urandom_range(300, 2);
      rh[i] = $urandom_range(rp[i] - 1, 1);
    end
    for (int i = 0; i < 9; i++) drive_period(rp[i], rh[i]);
    for (int i = 0; i < 8; i++) exp_q.push_back(edge_sample(rp[i], rh[i]));
    chk_samples("rnd", 20);

    // 2: one edge, high 10, then low forever.
    restart(1'b1);
    pwm_in = 1'b1;
    tick(10);
    pwm_in = 1'b0;
    exp_q.push_back(timeout_sample(10, 1'b0));
    chk_samples("t2", 4300);
    tick(500);
    chk("t2_quiet", 32'(got_q.size() - rd), 32'd0);
    drive_period(40, 15);
    chk("t2_rearm_only", 32'(got_q.size() - rd), 32'd0);
    pwm_in = 1'b1;
    tick(15);
    pwm_in = 1'b0;
    tick(5);
    exp_q.push_back(edge_sample(40, 15));
    chk_samples("t2_after", 20);

    // 3: constant high after an edge.
    restart(1'b1);
    pwm_in = 1'b1;
    exp_q.push_back(timeout_sample(5000, 1'b1));
    chk_samples("t3", 4300);
    pwm_in = 1'b0;
    tick(5);

    // 5: accept and load in the same cycle.
    restart(1'b0);
    drive_period(50, 20);
    drive_period(60, 25);
    chk("t5_pend", {31'd0, s_valid}, 32'd1);
    ovr_snap = ovr_cnt;
    pwm_in = 1'b1;
    tick(2);
    s_ready = 1'b1;
    tick(1);
    s_ready = 1'b0;
    chk("t5_valid", {31'd0, s_valid}, 32'd1);
    chk("t5_period", 32'(s_period), 32'd60);
    chk("t5_high", 32'(s_high), 32'd25);
    chk("t5_no_ovr", ovr_cnt - ovr_snap, 32'd0);
    exp_q.push_back(edge_sample(50, 20));
    chk_samples("t5_old", 5);
    tick(17);
    pwm_in = 1'b0;
    tick(10);
    s_ready = 1'b1;
    exp_q.push_back(edge_sample(60, 25));
    chk_samples("t5_new", 5);

    // 4: consumer stalled across three emits.
    restart(1'b0);
    ovr_snap = ovr_cnt;
    drive_period(100, 40);
    drive_period(110, 50);
    chk("t4_hold_a", 32'(s_period), 32'd100);
    drive_period(120, 60);
    pwm_in = 1'b1;
    tick(30);
    pwm_in = 1'b0;
    tick(10);
    chk("t4_valid", {31'd0, s_valid}, 32'd1);
    chk("t4_period", 32'(s_period), 32'd100);
    chk("t4_high", 32'(s_high), 32'd40);
    chk("t4_stuck", {31'd0, s_stuck}, 32'd0);
    chk("t4_ovr_pulses", ovr_cnt - ovr_snap, 32'd2);
    chk("t4_ovr_flag", {31'd0, overrun_flag}, 32'd1);
    chk("t4_none_taken", 32'(got_q.size() - rd), 32'd0);
    s_ready = 1'b1;
    exp_q.push_back(edge_sample(100, 40));
    chk_samples("t4_accept", 5);
    chk("t4_valid_fall", {31'd0, s_valid}, 32'd0);

    // 6: enable dropped mid-period, then reset mid-period.
    enable = 1'b0;
    tick(3);
    chk("t6_flag_clr", {31'd0, overrun_flag}, 32'd0);
    chk("t6_no_partial", {31'd0, s_valid}, 32'd0);
    chk("t6_no_partial_q", 32'(got_q.size() - rd), 32'd0);
    enable = 1'b1;
    tick(2);
    drive_period(70, 30);
    chk("t6_arm_only", {31'd0, s_valid}, 32'd0);
    s_ready = 1'b0;
    drive_period(80, 35);
    chk("t6_pend_period", 32'(s_period), 32'd70);
    chk("t6_pend_high", 32'(s_high), 32'd30);
    enable = 1'b0;
    tick(3);
    chk("t6_kept_valid", {31'd0, s_valid}, 32'd1);
    chk("t6_kept_period", 32'(s_period), 32'd70);
    enable = 1'b1;
    pwm_in = 1'b1;
    tick(5);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_flags", {27'd0, s_valid, s_stuck, s_level, overrun, overrun_flag}, 32'd0);
    chk("t6_rst_period", 32'(s_period), 32'd0);
    chk("t6_rst_high", 32'(s_high), 32'd0);
    pwm_in = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
